// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: the first valid requester after the last grant wins.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] idx;
    logic            found;

    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last) + i) % NUM_REQ);
            if (!found && valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of a flag-less shared FIFO, with its own occupancy count.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        rd_req,
    output logic                        fifo_we,
    output logic [DATA_W-1:0]           fifo_data,
    output logic                        fifo_re,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        full,
    output logic                        empty
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = idx_width(BURST_MAX);

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [ID_W-1:0]     winner;
    logic                any_valid;
    logic                accept;
    logic                rd_ok;
    logic [DATA_W-1:0]   owner_data;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid  (req_valid),
        .last   (grant_id),
        .winner (winner),
        .any    (any_valid)
    );

    // Flags come from the registered count only, so a write accepted this cycle cannot enable a read.
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign accept     = (state == BURST) && req_valid[grant_id] && !full;
    assign rd_ok      = rd_req && !empty;
    assign owner_data = req_data[grant_id*DATA_W +: DATA_W];

    always_comb begin
        req_ready = '0;
        if (state == BURST) req_ready[grant_id] = !full;
    end

    // NOTE: all state here is updated with <= so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant_id  <= ID_W'(NUM_REQ - 1);
            beat      <= '0;
            fifo_we   <= 1'b0;
            fifo_re   <= 1'b0;
            fifo_data <= '0;
            count     <= '0;
        end else begin
            fifo_we <= accept;
            fifo_re <= rd_ok;
            if (accept) fifo_data <= owner_data;

            if (accept && !rd_ok)      count <= count + 1'b1;
            else if (!accept && rd_ok) count <= count - 1'b1;

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        beat     <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        if (beat == BEAT_W'(BURST_MAX - 1)) state <= IDLE;
                        else                                beat  <= beat + 1'b1;
                    end else if (!req_valid[grant_id]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) count <= CNT_W'(DEPTH));
    a_no_full_wr:   assert property (@(posedge clk) disable iff (!rst) !(accept && full));
    a_no_empty_rd:  assert property (@(posedge clk) disable iff (!rst) !(rd_ok && empty));

endmodule
